chunked_adder_seq: RTL and testbench

Parametrised, multi-cycle successor to the team's 32-bit ripple-carry adder. It adds or subtracts two WIDTH-bit operands CHUNK bits per clock, starting at the LSB and carrying a registered carry between chunks. It flags signed overflow and self-checks the result against a single-cycle behavioural sum of the captured operands. It sits in the datapath test harness, where long operands must be added without a full-width carry chain in one cycle.

---
 rtl/chunked_adder_seq.sv | 89 ++++++++
 tb/tb_chunked_adder_seq.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/chunked_adder_seq.sv
// chunked_adder_seq: multi-cycle add/sub, CHUNK bits per cycle with a registered carry, ovf and self-check
module chunked_adder_seq #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             match
);
    localparam int N  = WIDTH / CHUNK;
    localparam int KW = N > 1 ? $clog2(N) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           r_state;
    logic [KW-1:0]    r_k;
    logic [WIDTH-1:0] r_a, r_b, r_p;
    logic             r_c, r_c0;
    logic [CHUNK-1:0] w_ac, w_bc;
    logic [CHUNK:0]   w_sum;
    logic [WIDTH-1:0] w_p, w_ref;
    logic             w_cm, w_last;
    always_comb begin
        w_ac   = r_a[r_k*CHUNK +: CHUNK];
        w_bc   = r_b[r_k*CHUNK +: CHUNK];
        w_sum  = {1'b0, w_ac} + {1'b0, w_bc} + {{CHUNK{1'b0}}, r_c};
        // carry into the top bit of the chunk, recovered from its sum bit
        w_cm   = w_ac[CHUNK-1] ^ w_bc[CHUNK-1] ^ w_sum[CHUNK-1];
        w_p    = r_p;
        w_p[r_k*CHUNK +: CHUNK] = w_sum[CHUNK-1:0];
        w_ref  = r_a + r_b + WIDTH'(r_c0);
        w_last = r_k == KW'(N - 1);
    end
    assign busy = r_state != IDLE;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_k     <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_p     <= '0;
            r_c     <= 1'b0;
            r_c0    <= 1'b0;
            done    <= 1'b0;
            s       <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
            match   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_a     <= a;
                    r_b     <= sub ? ~b : b;
                    r_c     <= sub | cin;
                    r_c0    <= sub | cin;
                    r_k     <= '0;
                    r_p     <= '0;
                    r_state <= RUN;
                end
                RUN: begin
                    r_c <= w_sum[CHUNK];
                    r_k <= r_k + KW'(1);
                    r_p <= w_p;
                    if (w_last) begin
                        r_state <= DONE;
                        done    <= 1'b1;
                        s       <= w_p;
                        cout    <= w_sum[CHUNK];
                        ovf     <= w_cm ^ w_sum[CHUNK];
                        match   <= w_p == w_ref;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_chunked_adder_seq.sv
// tb_chunked_adder_seq: four configurations run in lockstep against an arithmetic reference model
module tb_chunked_adder_seq;
    function automatic int wof(input int g);
        return g == 2 ? 64 : g == 3 ? 8 : 32;
    endfunction
    function automatic int cof(input int g);
        return g == 0 ? 8 : g == 1 ? 32 : g == 2 ? 16 : 1;
    endfunction
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b1;
    logic        cin = 1'b0;
    logic        sub = 1'b0;
    logic [63:0] a = '0;
    logic [63:0] b = '0;
    logic        busy_a[4], done_a[4], cout_a[4], ovf_a[4], match_a[4];
    logic [63:0] s_a[4];
    int          vecs = 0;
    int          errs = 0;
    always #5 clk = ~clk;
    for (genvar g = 0; g < 4; g++) begin : gi
        localparam int W = wof(g);
        localparam int C = cof(g);
        logic [W-1:0] sg;
        chunked_adder_seq #(.WIDTH(W), .CHUNK(C)) u_dut (
            .clk(clk), .rst(rst), .start(start), .a(a[W-1:0]), .b(b[W-1:0]),
            .cin(cin), .sub(sub), .busy(busy_a[g]), .done(done_a[g]), .s(sg),
            .cout(cout_a[g]), .ovf(ovf_a[g]), .match(match_a[g])
        );
        assign s_a[g] = 64'(sg);
    end
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic chkb(input string tag, input logic obs, input logic exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask
    task automatic chk_zero(input string tag);
        for (int g = 0; g < 4; g++) begin
            chkb($sformatf("%s g%0d busy", tag, g), busy_a[g], 1'b0);
            chkb($sformatf("%s g%0d done", tag, g), done_a[g], 1'b0);
            chk($sformatf("%s g%0d s", tag, g), s_a[g], 64'h0);
            chkb($sformatf("%s g%0d cout", tag, g), cout_a[g], 1'b0);
            chkb($sformatf("%s g%0d ovf", tag, g), ovf_a[g], 1'b0);
            chkb($sformatf("%s g%0d match", tag, g), match_a[g], 1'b0);
        end
    endtask
    // one operation on every configuration; all are idle again by cycle 10
    task automatic run_op(input logic [63:0] ia, input logic [63:0] ib, input logic icin, input logic isub);
        logic [63:0] es[4];
        logic        ec[4], eo[4];
        for (int g = 0; g < 4; g++) begin
            int          w = wof(g);
            logic [63:0] mask = w == 64 ? '1 : (64'd1 << w) - 64'd1;
            logic [63:0] ma = ia & mask;
            logic [63:0] mb = (isub ? ~ib : ib) & mask;
            logic [64:0] full = {1'b0, ma} + {1'b0, mb} + 65'(isub | icin);
            es[g] = full[63:0] & mask;
            ec[g] = full[w];
            eo[g] = (ma[w-1] == mb[w-1]) && (es[g][w-1] != ma[w-1]);
        end
        @(negedge clk);
        a = ia; b = ib; cin = icin; sub = isub; start = 1'b1;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            cin = ~icin;
            sub = ~isub;
            for (int g = 0; g < 4; g++) begin
                int n = wof(g) / cof(g);
                chkb($sformatf("g%0d busy c%0d", g, cyc), busy_a[g], cyc <= n + 1);
                chkb($sformatf("g%0d done c%0d", g, cyc), done_a[g], cyc == n + 1);
                if (cyc == n + 1) begin
                    chk($sformatf("g%0d s", g), s_a[g], es[g]);
                    chkb($sformatf("g%0d cout", g), cout_a[g], ec[g]);
                    chkb($sformatf("g%0d ovf", g), ovf_a[g], eo[g]);
                    chkb($sformatf("g%0d match", g), match_a[g], 1'b1);
                end
            end
        end
    endtask
    initial begin
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk_zero("reset");
        end
        rst = 1'b0;
        start = 1'b0;
        run_op(64'hFFFFFFFF, 64'h1, 1'b0, 1'b0);
        chk("ripple s", s_a[0], 64'h0);
        chkb("ripple cout", cout_a[0], 1'b1);
        chkb("ripple ovf", ovf_a[0], 1'b0);
        chkb("ripple match", match_a[0], 1'b1);
        run_op(64'h7FFFFFFF, 64'h1, 1'b0, 1'b0);
        chk("ovf s", s_a[0], 64'h80000000);
        chkb("ovf cout", cout_a[0], 1'b0);
        chkb("ovf ovf", ovf_a[0], 1'b1);
        run_op(64'h5, 64'h7, 1'b1, 1'b1);
        chk("sub s", s_a[0], 64'hFFFFFFFE);
        chkb("sub cout", cout_a[0], 1'b0);
        chkb("sub ovf", ovf_a[0], 1'b0);
        chkb("sub match", match_a[0], 1'b1);
        @(negedge clk);
        a = 64'h1; b = 64'h2; cin = 1'b0; sub = 1'b0; start = 1'b1;
        for (int cyc = 1; cyc <= 11; cyc++) begin
            @(negedge clk);
            chkb($sformatf("proto busy c%0d", cyc), busy_a[0], cyc != 6);
            chkb($sformatf("proto done c%0d", cyc), done_a[0], cyc == 5 || cyc == 11);
            chk($sformatf("proto s c%0d", cyc), s_a[0], cyc < 5 ? 64'hFFFFFFFE : cyc < 11 ? 64'd3 : 64'd30);
            start = cyc == 2 || cyc == 5 || cyc == 6;
            a = cyc == 2 ? 64'h100 : cyc == 5 ? 64'h55 : 64'd10;
            b = cyc == 2 ? 64'h100 : cyc == 5 ? 64'h22 : 64'd20;
        end
        start = 1'b0;
        repeat (12) @(negedge clk);
        a = 64'hFFFFFFFF; b = 64'h1; start = 1'b1;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (cyc == 4) chk_zero("midrst");
            if (cyc > 4) begin
                for (int g = 0; g < 4; g++)
                    chkb($sformatf("midrst g%0d done c%0d", g, cyc), done_a[g], 1'b0);
                chk($sformatf("midrst s c%0d", cyc), s_a[0], 64'h0);
            end
            rst = cyc == 3;
        end
        for (int i = 0; i < 1000; i++)
            run_op({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom));
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
